// File: rtl/cpu_ctrl_pkg.sv
// Shared types and defaults for the start/done run controller.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } run_state_t;

    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 1000;

endpackage

// File: rtl/run_controller_rise_detect.sv
// Rising-edge detector: registers the previous level and pulses for one
// cycle on a 0->1 transition.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign pulse = d & ~prev_q;

endmodule

// File: rtl/run_controller.sv
// Start/done sequencer: start edge -> PC load -> free run until halt or
// watchdog expiry. Optional single-step mode under RUN_CTRL_STEP_EN.
module run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
`ifdef RUN_CTRL_STEP_EN
    input  logic             step_mode,
    input  logic             step,
`endif
    output logic             pc_load,
    output logic             pc_en,
    output logic             run_en,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [CNT_W:0] TIMEOUT_V = TIMEOUT_CYCLES[CNT_W:0];

    run_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W-1:0] cnt_sat;
    logic             launch;
    logic             advance;

    rise_detect u_start_rise (
        .clk   (clk),
        .reset (reset),
        .d     (start),
        .pulse (launch)
    );

`ifdef RUN_CTRL_STEP_EN
    logic step_rise;

    rise_detect u_step_rise (
        .clk   (clk),
        .reset (reset),
        .d     (step),
        .pulse (step_rise)
    );

    // In step mode only a step edge lets RUN make progress.
    assign advance = ~step_mode | step_rise;
`else
    assign advance = 1'b1;
`endif

    // One extra bit catches the wrap so the counter can saturate.
    assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign cnt_sat = cnt_inc[CNT_W] ? cnt_q : cnt_inc[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (launch) state_d = INIT;
            end
            INIT: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (advance) begin
                    cnt_d = cnt_sat;
                    // halt takes priority over a watchdog expiring on the same cycle
                    if (halt) begin
                        state_d = DONE;
                    end else if (TIMEOUT_CYCLES != 0 && cnt_inc == TIMEOUT_V) begin
                        state_d = FAULT;
                    end
                end
            end
            DONE, FAULT: begin
                if (launch) state_d = INIT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pc_load = (state_q == INIT);
        run_en  = (state_q == RUN) & advance;
        pc_en   = (state_q == RUN) & advance & ~halt;
        busy    = (state_q == INIT) | (state_q == RUN);
        done    = (state_q == DONE);
        timeout = (state_q == FAULT);
    end

    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: two configurations (8-cycle watchdog,
// and disabled watchdog with a 3-bit saturating counter) driven in lockstep.
module tb_run_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, halt, step_mode, step;

    logic        a_pc_load, a_pc_en, a_run_en, a_busy, a_done, a_timeout;
    logic [15:0] a_cnt;
    logic        b_pc_load, b_pc_en, b_run_en, b_busy, b_done, b_timeout;
    logic [2:0]  b_cnt;

`ifdef RUN_CTRL_STEP_EN
    localparam bit HAS_STEP = 1'b1;
`else
    localparam bit HAS_STEP = 1'b0;
`endif

    run_controller #(.CNT_W(16), .TIMEOUT_CYCLES(8)) dut_a (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
`ifdef RUN_CTRL_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .pc_load(a_pc_load), .pc_en(a_pc_en), .run_en(a_run_en), .busy(a_busy),
        .done(a_done), .timeout(a_timeout), .cycle_count(a_cnt)
    );

    run_controller #(.CNT_W(3), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
`ifdef RUN_CTRL_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .pc_load(b_pc_load), .pc_en(b_pc_en), .run_en(b_run_en), .busy(b_busy),
        .done(b_done), .timeout(b_timeout), .cycle_count(b_cnt)
    );

    typedef struct {
        bit pc_load, pc_en, run_en, busy, done, timeout;
        int cnt;
    } exp_t;

    // Reference phases: 0 idle, 1 init, 2 run, 3 done, 4 fault
    typedef struct {
        int phase;
        int cnt;
    } model_t;

    exp_t   qa[$];
    exp_t   qb[$];
    model_t ma, mb;
    bit     start_prev, step_prev;
    int     checks = 0;
    int     errors = 0;

    function automatic exp_t m_out(model_t m, bit h, bit adv);
        exp_t e;
        e.pc_load = (m.phase == 1);
        e.run_en  = (m.phase == 2) && adv;
        e.pc_en   = (m.phase == 2) && adv && !h;
        e.busy    = (m.phase == 1) || (m.phase == 2);
        e.done    = (m.phase == 3);
        e.timeout = (m.phase == 4);
        e.cnt     = m.cnt;
        return e;
    endfunction

    function automatic model_t m_next(model_t m, bit rst, bit h, bit adv, bit launch,
                                      int tmo, int maxc);
        model_t n = m;
        if (rst) begin
            n.phase = 0;
            n.cnt   = 0;
        end else if (m.phase == 0 || m.phase == 3 || m.phase == 4) begin
            if (launch) n.phase = 1;
        end else if (m.phase == 1) begin
            n.phase = 2;
            n.cnt   = 0;
        end else if (adv) begin
            n.cnt = (m.cnt + 1 > maxc) ? maxc : m.cnt + 1;
            if (h) n.phase = 3;
            else if (tmo != 0 && m.cnt + 1 == tmo) n.phase = 4;
        end
        return n;
    endfunction

    task automatic cyc(input bit r, input bit s, input bit h, input bit sm = 0,
                       input bit st = 0);
        bit launch, adv;
        @(posedge clk);
        #1;
        reset     = r;
        start     = s;
        halt      = h;
        step_mode = HAS_STEP ? sm : 1'b0;
        step      = HAS_STEP ? st : 1'b0;
        launch = start && !start_prev;
        adv    = !step_mode || (step && !step_prev);
        qa.push_back(m_out(ma, h, adv));
        qb.push_back(m_out(mb, h, adv));
        ma = m_next(ma, r, h, adv, launch, 8, 65535);
        mb = m_next(mb, r, h, adv, launch, 0, 7);
        start_prev = r ? 1'b0 : start;
        step_prev  = r ? 1'b0 : step;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() != 0) begin
            e = qa.pop_front();
            chk("a.pc_load", a_pc_load, e.pc_load);
            chk("a.pc_en",   a_pc_en,   e.pc_en);
            chk("a.run_en",  a_run_en,  e.run_en);
            chk("a.busy",    a_busy,    e.busy);
            chk("a.done",    a_done,    e.done);
            chk("a.timeout", a_timeout, e.timeout);
            chk("a.cycle_count", int'(a_cnt), e.cnt);
        end
        if (qb.size() != 0) begin
            e = qb.pop_front();
            chk("b.pc_load", b_pc_load, e.pc_load);
            chk("b.pc_en",   b_pc_en,   e.pc_en);
            chk("b.run_en",  b_run_en,  e.run_en);
            chk("b.busy",    b_busy,    e.busy);
            chk("b.done",    b_done,    e.done);
            chk("b.timeout", b_timeout, e.timeout);
            chk("b.cycle_count", int'(b_cnt), e.cnt);
        end
    end

    initial begin
        bit s, sm, h;
        reset = 1'b1; start = 1'b0; halt = 1'b0; step_mode = 1'b0; step = 1'b0;
        ma = '{0, 0}; mb = '{0, 0};
        start_prev = 1'b0; step_prev = 1'b0;

        // Basic run: halt on 5th RUN cycle
        cyc(1, 0, 0); cyc(1, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        repeat (4) cyc(0, 0, 0);
        cyc(0, 0, 1);
        repeat (4) cyc(0, 0, 0);

        // Held start gives one launch; re-launch after a low cycle
        cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 1, 1);
        repeat (15) cyc(0, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 1, 1);
        repeat (3) cyc(0, 0, 0);

        // Watchdog expiry on A; B keeps running and saturates
        cyc(0, 1, 0); cyc(0, 0, 0);
        repeat (11) cyc(0, 0, 0);
        cyc(0, 0, 1);
        repeat (3) cyc(0, 0, 1);

        // Halt coincides with the watchdog limit
        cyc(0, 1, 0); cyc(0, 0, 0);
        repeat (7) cyc(0, 0, 0);
        cyc(0, 0, 1);
        repeat (3) cyc(0, 0, 0);

        // Reset mid-run, then a normal launch
        cyc(0, 1, 0); cyc(0, 0, 0);
        repeat (3) cyc(0, 0, 0);
        cyc(1, 0, 0);
        repeat (2) cyc(0, 0, 0);
        cyc(0, 1, 0); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 1);
        repeat (2) cyc(0, 0, 0);

        // Step mode: three spaced step pulses, halt ignored while stalled
        if (HAS_STEP) begin
            cyc(0, 1, 0, 1, 0); cyc(0, 0, 0, 1, 0);
            for (int i = 0; i < 3; i++) begin
                cyc(0, 0, 0, 1, 1);
                cyc(0, 0, 1, 1, 1);
                cyc(0, 0, 1, 1, 0);
                cyc(0, 0, 0, 1, 0);
            end
            cyc(0, 0, 1, 1, 1);
            repeat (3) cyc(0, 0, 0, 0, 0);
        end

        // Randomized traffic
        s = 0; sm = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) s = !s;
            if (HAS_STEP && $urandom_range(0, 199) == 0) sm = !sm;
            h = ($urandom_range(0, 11) == 0);
            cyc(($urandom_range(0, 99) == 0), s, h, sm, ($urandom_range(0, 2) == 0));
        end
        cyc(0, 0, 0);

        for (int i = 0; i < 10 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
        @(posedge clk);
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", qa.size() + qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
